// File: rtl/control_lecturas_rafaga_mem_externa_pkg.sv
// Shared FSM encoding, default widths and small helpers for the burst-read controller.
package control_lecturas_pkg;

  localparam int BITS_DIRECCION_DEF    = 21;
  localparam int BITS_CONTADOR_DEF     = 12;
  localparam int BYTES_POR_PALABRA_DEF = 4;
  localparam int MAX_PENDIENTES_DEF    = 4;
  localparam int BITS_ESPACIO_DEF      = 8;

  typedef enum logic [1:0] {
    E_INICIO = 2'd0,
    E_EMITIR = 2'd1,
    E_DRENAR = 2'd2,
    E_FIN    = 2'd3
  } estado_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/control_lecturas_rafaga_mem_externa_generador_direcciones_2d.sv
// 2-D window address walker: latches base/pitch/dimensions on cargar_i and
// steps one word per avanzar_i, jumping to the next row start at end of row.
module generador_direcciones_2d
  import control_lecturas_pkg::*;
#(
  parameter int BITS_DIRECCION    = BITS_DIRECCION_DEF,
  parameter int BITS_CONTADOR     = BITS_CONTADOR_DEF,
  parameter int BYTES_POR_PALABRA = BYTES_POR_PALABRA_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cargar_i,
  input  logic                      avanzar_i,
  input  logic [BITS_DIRECCION-1:0] direccion_inicio_i,
  input  logic [BITS_DIRECCION-1:0] paso_fila_i,
  input  logic [BITS_CONTADOR-1:0]  filas_i,
  input  logic [BITS_CONTADOR-1:0]  palabras_por_fila_i,
  output logic [BITS_DIRECCION-1:0] direccion_o,
  output logic                      ultima_palabra_o
);

  localparam logic [BITS_DIRECCION-1:0] INC_PALABRA = BITS_DIRECCION'(BYTES_POR_PALABRA);
  localparam logic [BITS_CONTADOR-1:0]  UNO         = BITS_CONTADOR'(1);

  logic [BITS_DIRECCION-1:0] base_fila_q, base_fila_d;
  logic [BITS_DIRECCION-1:0] direccion_q, direccion_d;
  logic [BITS_DIRECCION-1:0] paso_q;
  logic [BITS_CONTADOR-1:0]  col_q, col_d;
  logic [BITS_CONTADOR-1:0]  fila_q, fila_d;
  logic [BITS_CONTADOR-1:0]  ppf_q, filas_q;
  logic                      fin_columna;

  assign fin_columna      = (col_q == (ppf_q - UNO));
  assign ultima_palabra_o = fin_columna && (fila_q == (filas_q - UNO));
  assign direccion_o      = direccion_q;

  // All address arithmetic wraps naturally at BITS_DIRECCION.
  always_comb begin
    base_fila_d = base_fila_q;
    direccion_d = direccion_q;
    col_d       = col_q;
    fila_d      = fila_q;
    if (cargar_i) begin
      base_fila_d = direccion_inicio_i;
      direccion_d = direccion_inicio_i;
      col_d       = '0;
      fila_d      = '0;
    end else if (avanzar_i) begin
      if (fin_columna) begin
        col_d       = '0;
        fila_d      = fila_q + UNO;
        base_fila_d = base_fila_q + paso_q;
        direccion_d = base_fila_q + paso_q;
      end else begin
        col_d       = col_q + UNO;
        direccion_d = direccion_q + INC_PALABRA;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_fila_q <= '0;
      direccion_q <= '0;
      paso_q      <= '0;
      col_q       <= '0;
      fila_q      <= '0;
      ppf_q       <= '0;
      filas_q     <= '0;
    end else begin
      base_fila_q <= base_fila_d;
      direccion_q <= direccion_d;
      col_q       <= col_d;
      fila_q      <= fila_d;
      if (cargar_i) begin
        paso_q  <= paso_fila_i;
        ppf_q   <= palabras_por_fila_i;
        filas_q <= filas_i;
      end
    end
  end

endmodule

// File: rtl/control_lecturas_rafaga_mem_externa.sv
// Burst-read controller fetching a filas x palabras_por_fila window over an Avalon-style
// read port with credit flow control. Optional abort input: CONTROL_LECTURAS_ABORTAR_EN.
module control_lecturas_rafaga_mem_externa
  import control_lecturas_pkg::*;
#(
  parameter int BITS_DIRECCION    = BITS_DIRECCION_DEF,
  parameter int BITS_CONTADOR     = BITS_CONTADOR_DEF,
  parameter int BYTES_POR_PALABRA = BYTES_POR_PALABRA_DEF,
  parameter int MAX_PENDIENTES    = MAX_PENDIENTES_DEF,
  parameter int BITS_ESPACIO      = BITS_ESPACIO_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      iniciar,
  input  logic [BITS_DIRECCION-1:0] direccion_inicio,
  input  logic [BITS_CONTADOR-1:0]  filas,
  input  logic [BITS_CONTADOR-1:0]  palabras_por_fila,
  input  logic [BITS_DIRECCION-1:0] paso_fila,
  input  logic [BITS_ESPACIO-1:0]   buf_espacio_libre,
  input  logic                      mem_waitrequest,
  input  logic                      lectura_mem_completada,
`ifdef CONTROL_LECTURAS_ABORTAR_EN
  input  logic                      abortar,
`endif
  output logic                      read_mem,
  output logic [BITS_DIRECCION-1:0] address_mem,
  output logic                      save_mem_data,
  output logic                      ocupado,
  output logic                      fin,
  output logic                      error_respuesta
);

  localparam int BITS_PEND = $clog2(MAX_PENDIENTES + 1);
  localparam int BITS_CMP  = max_int(BITS_PEND, BITS_ESPACIO);
  localparam logic [BITS_PEND-1:0] PEND_MAX = BITS_PEND'(MAX_PENDIENTES);
  localparam logic [BITS_PEND-1:0] PEND_UNO = BITS_PEND'(1);

  estado_t                  estado_q;
  logic [BITS_PEND-1:0]     pendientes_q, pendientes_d;
  logic                     read_mem_q;
  logic                     fin_q;
  logic                     error_q;

  logic                     aceptada;
  logic                     decrementa;
  logic                     error_evento;
  logic                     puede_emitir;
  logic                     dims_validas;
  logic                     arranque;
  logic                     ultima_palabra;
  logic                     parar;
  logic [BITS_DIRECCION-1:0] direccion_gen;

  assign aceptada     = read_mem_q && !mem_waitrequest;
  assign decrementa   = lectura_mem_completada && (pendientes_q != '0);
  assign error_evento = lectura_mem_completada && (pendientes_q == '0);
  assign dims_validas = (filas != '0) && (palabras_por_fila != '0);
  assign arranque     = (estado_q == E_INICIO) && iniciar;

  always_comb begin
    pendientes_d = pendientes_q;
    if (aceptada && !decrementa)
      pendientes_d = pendientes_q + PEND_UNO;
    else if (!aceptada && decrementa)
      pendientes_d = pendientes_q - PEND_UNO;
  end

  // Issue rule looks at next-cycle occupancy so back-to-back requests stay within the credit.
  assign puede_emitir = (pendientes_d < PEND_MAX) &&
                        (BITS_CMP'(buf_espacio_libre) > BITS_CMP'(pendientes_d));

`ifdef CONTROL_LECTURAS_ABORTAR_EN
  logic aborto_q;

  // Remembers an abort seen while a request was still stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      aborto_q <= 1'b0;
    else if (estado_q != E_EMITIR)
      aborto_q <= 1'b0;
    else if (abortar)
      aborto_q <= 1'b1;
  end

  assign parar = abortar || aborto_q;
`else
  assign parar = 1'b0;
`endif

  generador_direcciones_2d #(
    .BITS_DIRECCION    (BITS_DIRECCION),
    .BITS_CONTADOR     (BITS_CONTADOR),
    .BYTES_POR_PALABRA (BYTES_POR_PALABRA)
  ) u_generador (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cargar_i            (arranque),
    .avanzar_i           (aceptada),
    .direccion_inicio_i  (direccion_inicio),
    .paso_fila_i         (paso_fila),
    .filas_i             (filas),
    .palabras_por_fila_i (palabras_por_fila),
    .direccion_o         (direccion_gen),
    .ultima_palabra_o    (ultima_palabra)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q     <= E_INICIO;
      pendientes_q <= '0;
      read_mem_q   <= 1'b0;
      fin_q        <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      pendientes_q <= pendientes_d;
      fin_q        <= 1'b0;
      if (error_evento)
        error_q <= 1'b1;
      case (estado_q)
        E_INICIO: begin
          if (iniciar) begin
            error_q <= 1'b0;
            if (dims_validas) begin
              estado_q   <= E_EMITIR;
              read_mem_q <= puede_emitir;
            end else begin
              estado_q <= E_FIN;
            end
          end
        end
        E_EMITIR: begin
          // A raised request is never withdrawn; decisions happen only when the port is free.
          if (aceptada) begin
            if (ultima_palabra || parar) begin
              read_mem_q <= 1'b0;
              estado_q   <= E_DRENAR;
            end else begin
              read_mem_q <= puede_emitir;
            end
          end else if (!read_mem_q) begin
            if (parar)
              estado_q <= E_DRENAR;
            else
              read_mem_q <= puede_emitir;
          end
        end
        E_DRENAR: begin
          if (pendientes_d == '0)
            estado_q <= E_FIN;
        end
        E_FIN: begin
          fin_q    <= 1'b1;
          estado_q <= E_INICIO;
        end
        default: estado_q <= E_INICIO;
      endcase
    end
  end

  assign read_mem        = read_mem_q;
  assign address_mem     = direccion_gen;
  assign save_mem_data   = lectura_mem_completada;
  assign ocupado         = (estado_q != E_INICIO);
  assign fin             = fin_q;
  assign error_respuesta = error_q;

endmodule

// File: tb/tb_control_lecturas_rafaga_mem_externa.sv
// Scoreboard bench: directed transfers push hand-computed addresses; a negedge monitor checks every accepted read.
module tb_control_lecturas_rafaga_mem_externa;

  logic        clk;
  logic        reset_n;
  logic        iniciar;
  logic [20:0] direccion_inicio;
  logic [11:0] filas;
  logic [11:0] palabras_por_fila;
  logic [20:0] paso_fila;
  logic [7:0]  buf_espacio_libre;
  logic        mem_waitrequest;
  logic        lectura_mem_completada;
  logic        abortar;
  logic        read_mem;
  logic [20:0] address_mem;
  logic        save_mem_data;
  logic        ocupado;
  logic        fin;
  logic        error_respuesta;

  control_lecturas_rafaga_mem_externa dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .iniciar                (iniciar),
    .direccion_inicio       (direccion_inicio),
    .filas                  (filas),
    .palabras_por_fila      (palabras_por_fila),
    .paso_fila              (paso_fila),
    .buf_espacio_libre      (buf_espacio_libre),
    .mem_waitrequest        (mem_waitrequest),
    .lectura_mem_completada (lectura_mem_completada),
`ifdef CONTROL_LECTURAS_ABORTAR_EN
    .abortar                (abortar),
`endif
    .read_mem               (read_mem),
    .address_mem            (address_mem),
    .save_mem_data          (save_mem_data),
    .ocupado                (ocupado),
    .fin                    (fin),
    .error_respuesta        (error_respuesta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [20:0] exp_q[$];

  // Monitor-owned state
  int acc_total = 0;
  int outst     = 0;
  int limit     = 4;
  bit hold_prev = 0;
  logic [20:0] hold_addr;

  // Responder-owned state
  int resp_total = 0;
  int extra_done = 0;
  // Stimulus-owned knobs
  int resp_limit = 1 << 30;
  int extra_req  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: one response per accepted word, one cycle later, throttled by resp_limit.
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      lectura_mem_completada = 1'b0;
      resp_total = acc_total;
    end else if (extra_done < extra_req) begin
      lectura_mem_completada = 1'b1;
      extra_done++;
    end else if ((acc_total - resp_total) > 0 && resp_total < resp_limit) begin
      lectura_mem_completada = 1'b1;
      resp_total++;
    end else begin
      lectura_mem_completada = 1'b0;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [20:0] e;
    if (!reset_n) begin
      outst = 0;
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        check("hold_read_mem", 32'(read_mem), 32'd1);
        check("hold_address", 32'(address_mem), 32'(hold_addr));
      end
      hold_prev = read_mem && mem_waitrequest;
      hold_addr = address_mem;
      if (lectura_mem_completada) begin
        check("save_mem_data", 32'(save_mem_data), 32'd1);
        if (outst > 0) outst--;
      end
      if (read_mem && !mem_waitrequest) begin
        acc_total++;
        outst++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read: got address %0h expected no request", address_mem);
        end else begin
          e = exp_q.pop_front();
          check("read_address", 32'(address_mem), 32'(e));
        end
        check("pending_bound", 32'(outst > limit), 32'd0);
      end
    end
  end

  task automatic start(input logic [20:0] base, input logic [11:0] f, input logic [11:0] p,
                       input logic [20:0] paso);
    @(posedge clk); #1;
    direccion_inicio  = base;
    filas             = f;
    palabras_por_fila = p;
    paso_fila         = paso;
    iniciar           = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
  endtask

  task automatic wait_fin(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (fin) seen = 1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic cycle;
    @(posedge clk); #1;
  endtask

  initial begin
    int a0;
    int r0;
    iniciar = 0; direccion_inicio = 0; filas = 0; palabras_por_fila = 0; paso_fila = 0;
    buf_espacio_libre = 8'd16; mem_waitrequest = 0; abortar = 0;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #20;
    check("reset_read_mem", 32'(read_mem), 32'd0);
    check("reset_address", 32'(address_mem), 32'd0);
    check("reset_ocupado", 32'(ocupado), 32'd0);
    check("reset_fin", 32'(fin), 32'd0);
    check("reset_error", 32'(error_respuesta), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // 1: 2x3 window, pitch 0x40, immediate responses
    limit = 1;
    r0 = resp_total;
    exp_q.push_back(21'h100); exp_q.push_back(21'h104); exp_q.push_back(21'h108);
    exp_q.push_back(21'h140); exp_q.push_back(21'h144); exp_q.push_back(21'h148);
    start(21'h100, 12'd2, 12'd3, 21'h40);
    check("t1_first_read_latency", 32'(read_mem), 32'd1);
    check("t1_first_address", 32'(address_mem), 32'h100);
    check("t1_ocupado", 32'(ocupado), 32'd1);
    wait_fin("t1_fin", 40);
    check("t1_all_words", 32'(exp_q.size()), 32'd0);
    check("t1_responses_before_fin", 32'(resp_total - r0), 32'd6);
    @(negedge clk);
    check("t1_fin_one_cycle", 32'(fin), 32'd0);

    // 2: stall on second request while buffer space drops to 0
    limit = 4;
    exp_q.push_back(21'h100); exp_q.push_back(21'h104); exp_q.push_back(21'h108);
    start(21'h100, 12'd1, 12'd3, 21'h40);
    cycle;
    mem_waitrequest = 1'b1; buf_espacio_libre = 8'd0;
    cycle;
    cycle;
    check("t2_held_read", 32'(read_mem), 32'd1);
    check("t2_held_address", 32'(address_mem), 32'h104);
    cycle;
    mem_waitrequest = 1'b0; buf_espacio_libre = 8'd16;
    wait_fin("t2_fin", 40);
    check("t2_all_words", 32'(exp_q.size()), 32'd0);

    // 3: responses withheld -> credit limit of 4 in flight
    resp_limit = resp_total;
    a0 = acc_total;
    for (int i = 0; i < 8; i++) exp_q.push_back(21'h200 + 21'(4 * i));
    start(21'h200, 12'd1, 12'd8, 21'h0);
    repeat (12) cycle;
    check("t3_four_accepted", 32'(acc_total - a0), 32'd4);
    check("t3_read_low", 32'(read_mem), 32'd0);
    resp_limit = resp_total + 1;
    repeat (6) cycle;
    check("t3_one_more", 32'(acc_total - a0), 32'd5);
    check("t3_read_low_again", 32'(read_mem), 32'd0);
    resp_limit = 1 << 30;
    wait_fin("t3_fin", 60);
    check("t3_all_words", 32'(exp_q.size()), 32'd0);

    // 4: single free slot -> at most one in flight
    limit = 1;
    buf_espacio_libre = 8'd1;
    r0 = resp_total;
    exp_q.push_back(21'h300); exp_q.push_back(21'h304);
    exp_q.push_back(21'h310); exp_q.push_back(21'h314);
    start(21'h300, 12'd2, 12'd2, 21'h10);
    wait_fin("t4_fin", 60);
    check("t4_all_words", 32'(exp_q.size()), 32'd0);
    check("t4_responses", 32'(resp_total - r0), 32'd4);
    buf_espacio_libre = 8'd16;
    limit = 4;

    // 5: zero rows -> no reads, fin two cycles after iniciar, then stray response
    start(21'h000, 12'd0, 12'd3, 21'h40);
    check("t5_no_read", 32'(read_mem), 32'd0);
    check("t5_fin_not_yet", 32'(fin), 32'd0);
    cycle;
    check("t5_fin", 32'(fin), 32'd1);
    extra_req++;
    cycle;
    cycle;
    check("t5_error_set", 32'(error_respuesta), 32'd1);
    exp_q.push_back(21'h500);
    start(21'h500, 12'd1, 12'd1, 21'h0);
    check("t5_error_cleared", 32'(error_respuesta), 32'd0);
    wait_fin("t5_fin_after_clear", 30);

    // 6: asynchronous reset mid-transfer
    exp_q.push_back(21'h400); exp_q.push_back(21'h404);
    start(21'h400, 12'd1, 12'd8, 21'h0);
    cycle;
    cycle;
    reset_n = 1'b0;
    #1;
    check("t6_async_read_mem", 32'(read_mem), 32'd0);
    check("t6_async_address", 32'(address_mem), 32'd0);
    check("t6_async_ocupado", 32'(ocupado), 32'd0);
    cycle;
    reset_n = 1'b1;
    check("t6_words_before_reset", 32'(exp_q.size()), 32'd0);
    repeat (3) cycle;
    check("t6_idle_after_reset", 32'(ocupado), 32'd0);
    check("t6_no_error", 32'(error_respuesta), 32'd0);

`ifdef CONTROL_LECTURAS_ABORTAR_EN
    exp_q.push_back(21'h600); exp_q.push_back(21'h604);
    start(21'h600, 12'd1, 12'd8, 21'h0);
    cycle;
    abortar = 1'b1;
    cycle;
    abortar = 1'b0;
    check("t6_abort_read_low", 32'(read_mem), 32'd0);
    wait_fin("t6_abort_fin", 30);
    check("t6_abort_words", 32'(exp_q.size()), 32'd0);
`endif

    repeat (4) cycle;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
